inst_mem_dbuf: RTL and testbench
================================

// Module: inst_mem_dbuf
// PURPOSE
//  Double-buffered FSM instruction/constant memory, loaded over a PROG_WIDTH-bit valid/ready stream.
//  A frame loads a shadow bank and is copied atomically to the active bank on commit.
//  The running FSM therefore never reads a partially programmed image.
//  Sits between the programming interface and the FSM core: state-word read port plus constant read port.
// PARAMETERS
//  STATE_COUNT   8   number of state words (need not be a power of two)
//  COND_WIDTH    1   condition-select field width
//  ACTION_WIDTH  1   then/else action field width
//  CONST_WIDTH  16   constant word width
//  CONST_COUNT   2   number of constant words
//  PROG_WIDTH    4   bits accepted per programming beat (>=1)
//  Derived: SW=clog2(STATE_COUNT), WORD=SW+COND_WIDTH+2*ACTION_WIDTH,
//  MEM=CONST_WIDTH*CONST_COUNT+WORD*STATE_COUNT, BEATS=ceil(MEM/PROG_WIDTH)
// PORTS
//  clock        in   1             system clock, rising edge
//  rst          in   1             asynchronous reset, active-high
//  prog_start   in   1             pulse: begin new frame
//  prog_valid   in   1             beat valid
//  prog_data    in   PROG_WIDTH    beat payload
//  prog_ready   out  1             beat accept
//  prog_done    out  1             shadow holds complete frame
//  prog_commit  in   1             pulse: copy shadow to active
//  commit_err   out  1             1-cycle pulse: commit rejected
//  mem_valid    out  1             active bank committed at least once
//  addr         in   SW            state word address
//  jump_target  out  SW            word[SW-1:0]
//  cond         out  COND_WIDTH    next COND_WIDTH bits above jump_target
//  then_action  out  ACTION_WIDTH  next ACTION_WIDTH bits above cond
//  else_action  out  ACTION_WIDTH  top ACTION_WIDTH bits of word
//  const_addr   in   clog2(CONST_COUNT)  constant address
//  const_data   out  CONST_WIDTH   constant word
// BEHAVIOUR
//  Reset (async, any state):
//   - shadow and active banks cleared to 0; state IDLE; beat counter 0.
//   - prog_ready=0, prog_done=0, commit_err=0, mem_valid=0.
//   - All read outputs are 0.
//  FSM states:
//   - IDLE: prog_ready=0.
//   - LOAD: prog_ready=1; beat accepted when prog_valid&prog_ready; shadow <= {shadow,prog_data}; cnt++.
//     Acceptance of beat BEATS-1 -> FULL.
//   - FULL: prog_ready=0, prog_done=1. prog_commit -> active<=shadow[MEM-1:0], mem_valid<=1, -> IDLE.
//  prog_start in any state -> LOAD, cnt=0, prog_done=0; shadow not cleared (overwritten by the frame).
//   - prog_start has priority over a same-cycle beat or commit; that beat/commit is dropped, no error.
//  prog_commit in IDLE or LOAD (without prog_start): no copy; commit_err=1 next cycle for one cycle.
//  Bit order: first beat ends up most significant; prog_data MSB is more significant.
//   - Pad bits (BEATS*PROG_WIDTH-MEM) are the first beat's top bits and are discarded.
//  Active layout: consts at [0 +: CONST_WIDTH*CONST_COUNT], const k at k*CONST_WIDTH.
//   - State word i at CONST_WIDTH*CONST_COUNT + i*WORD.
//  Reads are combinational from the active bank; a commit is visible the cycle after the commit edge.
//  Loading shadow never alters read outputs.
//  addr>=STATE_COUNT or const_addr>=CONST_COUNT -> corresponding outputs 0.
// TESTING
//  Defaults: MEM=80, BEATS=20.
//  1. Reset, then any addr/const_addr -> all outputs 0, mem_valid=0, prog_ready=0.
//  2. start + 20 beats + commit. Image: const0=16'hBEEF, const1=16'h1234, word3 = {else=1,then=0,cond=1,jt=3'd5}.
//     -> const_data 16'hBEEF/16'h1234; addr=3 gives jt=5, cond=1, then=0, else=1; mem_valid=1.
//  3. Hold prog_valid with random gaps. -> Only valid&ready beats counted; prog_done rises exactly after beat 20;
//     prog_ready=0 in FULL.
//  4. Commit after 7 beats -> commit_err pulses once; outputs unchanged; continue 13 beats and commit -> new image live.
//  5. Reload a second image without committing -> reads still return first image; commit -> second image next cycle.
//  6. Assert rst mid-LOAD (async, between edges) -> outputs/banks 0 immediately, state IDLE; prog_start in FULL restarts count.

Source files
------------

// File: rtl/inst_mem_dbuf.sv
// Double-buffered instruction/constant memory for the sequencer FSM core.
// A frame streams into a shadow bank; commit copies it atomically to the active bank.
module inst_mem_dbuf #(
  parameter int STATE_COUNT  = 8,
  parameter int COND_WIDTH   = 1,
  parameter int ACTION_WIDTH = 1,
  parameter int CONST_WIDTH  = 16,
  parameter int CONST_COUNT  = 2,
  parameter int PROG_WIDTH   = 4,
  localparam int SW  = (STATE_COUNT > 1) ? $clog2(STATE_COUNT) : 1,
  localparam int CAW = (CONST_COUNT > 1) ? $clog2(CONST_COUNT) : 1
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    prog_start,
  input  logic                    prog_valid,
  input  logic [PROG_WIDTH-1:0]   prog_data,
  output logic                    prog_ready,
  output logic                    prog_done,
  input  logic                    prog_commit,
  output logic                    commit_err,
  output logic                    mem_valid,
  input  logic [SW-1:0]           addr,
  output logic [SW-1:0]           jump_target,
  output logic [COND_WIDTH-1:0]   cond,
  output logic [ACTION_WIDTH-1:0] then_action,
  output logic [ACTION_WIDTH-1:0] else_action,
  input  logic [CAW-1:0]          const_addr,
  output logic [CONST_WIDTH-1:0]  const_data
);

  // state | meaning
  // IDLE  | no frame in progress, shadow not known complete
  // LOAD  | accepting beats into the shadow bank
  // FULL  | shadow holds a complete frame, waiting for commit

  localparam int WORD  = SW + COND_WIDTH + 2 * ACTION_WIDTH;
  localparam int CBITS = CONST_WIDTH * CONST_COUNT;
  localparam int MEM   = CBITS + WORD * STATE_COUNT;
  localparam int BEATS = (MEM + PROG_WIDTH - 1) / PROG_WIDTH;
  localparam int SH    = BEATS * PROG_WIDTH;
  localparam int CW    = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [SH-1:0]    shadow;
  logic [MEM-1:0]   active;
  logic [WORD-1:0]  word;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      prog_ready <= 1'b0;
      prog_done  <= 1'b0;
      commit_err <= 1'b0;
      mem_valid  <= 1'b0;
    end else begin
      commit_err <= 1'b0;
      if (prog_start) begin
        // a same-cycle beat or commit is silently dropped
        state      <= LOAD;
        cnt        <= '0;
        prog_ready <= 1'b1;
        prog_done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (prog_commit) commit_err <= 1'b1;
          end
          LOAD: begin
            if (prog_commit) commit_err <= 1'b1;
            if (prog_valid && prog_ready) begin
              // first beat shifts up to the most significant end; pad bits fall off the top
              shadow <= (shadow << PROG_WIDTH) | SH'(prog_data);
              if (cnt == CW'(BEATS - 1)) begin
                state      <= FULL;
                prog_ready <= 1'b0;
                prog_done  <= 1'b1;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          FULL: begin
            if (prog_commit) begin
              active    <= shadow[MEM-1:0];
              mem_valid <= 1'b1;
              prog_done <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            state      <= IDLE;
            prog_ready <= 1'b0;
            prog_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Out-of-range addresses match no entry and read back as zero.
  always_comb begin
    word        = '0;
    jump_target = '0;
    cond        = '0;
    then_action = '0;
    else_action = '0;
    for (int i = 0; i < STATE_COUNT; i++) begin
      if (addr == SW'(i)) word = active[CBITS + i * WORD +: WORD];
    end
    jump_target = word[SW-1:0];
    cond        = word[SW +: COND_WIDTH];
    then_action = word[SW + COND_WIDTH +: ACTION_WIDTH];
    else_action = word[WORD-1 -: ACTION_WIDTH];
  end

  always_comb begin
    const_data = '0;
    for (int k = 0; k < CONST_COUNT; k++) begin
      if (const_addr == CAW'(k)) const_data = active[k * CONST_WIDTH +: CONST_WIDTH];
    end
  end

endmodule

// File: tb/tb_inst_mem_dbuf.sv
// Scoreboard bench for inst_mem_dbuf at default parameters (MEM=80, BEATS=20).
module tb_inst_mem_dbuf;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        prog_start = 1'b0;
  logic        prog_valid = 1'b0;
  logic [3:0]  prog_data = '0;
  logic        prog_ready;
  logic        prog_done;
  logic        prog_commit = 1'b0;
  logic        commit_err;
  logic        mem_valid;
  logic [2:0]  addr = '0;
  logic [2:0]  jump_target;
  logic [0:0]  cond;
  logic [0:0]  then_action;
  logic [0:0]  else_action;
  logic [0:0]  const_addr = '0;
  logic [15:0] const_data;

  inst_mem_dbuf dut (
    .clock(clock), .rst(rst),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(prog_ready), .prog_done(prog_done),
    .prog_commit(prog_commit), .commit_err(commit_err), .mem_valid(mem_valid),
    .addr(addr), .jump_target(jump_target), .cond(cond),
    .then_action(then_action), .else_action(else_action),
    .const_addr(const_addr), .const_data(const_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   err_pulses = 0;

  // image layout: {w7..w0, const1, const0}; word = {else, then, cond, jt[2:0]}
  localparam logic [79:0] IMG1 = {6'h00, 6'h00, 6'h00, 6'h00, 6'h2D, 6'h00, 6'h00, 6'h00,
                                  16'h1234, 16'hBEEF};
  localparam logic [79:0] IMG2 = {6'b111010, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                  6'b010111, 16'h0F0F, 16'hCAFE};

  function automatic logic [31:0] actual(int kind);
    case (kind)
      0: return 32'(const_data);
      1: return 32'(jump_target);
      2: return 32'(cond);
      3: return 32'(then_action);
      4: return 32'(else_action);
      5: return 32'(mem_valid);
      6: return 32'(prog_ready);
      7: return 32'(prog_done);
      8: return 32'(commit_err);
      default: return 32'(err_pulses);
    endcase
  endfunction

  always @(negedge clock) begin
    exp_t e;
    logic [31:0] a;
    if (commit_err === 1'b1) err_pulses++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual(e.kind);
      checks++;
      if (a !== e.val) begin
        failures++;
        $display("FAIL %s: got %0h expected %0h at %0t", e.name, a, e.val, $time);
      end
    end
  end

  task automatic expect_val(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    @(negedge clock);
    #1;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_image(input string tag, input logic [79:0] img);
    logic [5:0] w;
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      const_addr = 1'(i % 2);
      w = img[32 + 6 * i +: 6];
      expect_val({tag, "_jt"}, 1, 32'(w[2:0]));
      expect_val({tag, "_cond"}, 2, 32'(w[3]));
      expect_val({tag, "_then"}, 3, 32'(w[4]));
      expect_val({tag, "_else"}, 4, 32'(w[5]));
      expect_val({tag, "_const"}, 0, 32'(img[16 * (i % 2) +: 16]));
      drain();
    end
  endtask

  task automatic pulse_start();
    prog_start = 1'b1;
    cycle();
    prog_start = 1'b0;
  endtask

  task automatic pulse_commit();
    prog_commit = 1'b1;
    cycle();
    prog_commit = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] d);
    int n;
    n = 0;
    prog_valid = 1'b1;
    prog_data = d;
    while (prog_ready !== 1'b1 && n <= 50) begin
      cycle();
      n++;
    end
    if (n > 50) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: prog_ready stayed %b, required 1", prog_ready);
    end else begin
      cycle();
    end
    prog_valid = 1'b0;
    prog_data = 4'hF;
  endtask

  task automatic send_beats(input logic [79:0] img, input int first, input int last,
                            input bit gaps);
    for (int b = first; b <= last; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          prog_valid = 1'b0;
          prog_data = 4'(b);
          cycle();
        end
      end
      send_beat(img[79 - 4 * b -: 4]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset state
    #12;
    addr = 3'd3; const_addr = 1'b1;
    expect_val("rst_const", 0, 0);
    expect_val("rst_jt", 1, 0);
    expect_val("rst_else", 4, 0);
    expect_val("rst_valid", 5, 0);
    expect_val("rst_ready", 6, 0);
    expect_val("rst_done", 7, 0);
    drain();
    rst = 1'b0;
    cycle();

    // 2: straight load and commit
    pulse_start();
    expect_val("load_ready", 6, 1);
    drain();
    send_beats(IMG1, 0, 19, 1'b0);
    expect_val("t2_done", 7, 1);
    expect_val("t2_ready_full", 6, 0);
    expect_val("t2_valid_pre", 5, 0);
    drain();
    pulse_commit();
    addr = 3'd3; const_addr = 1'b0;
    expect_val("t2_const0", 0, 32'hBEEF);
    expect_val("t2_w3_jt", 1, 5);
    expect_val("t2_w3_cond", 2, 1);
    expect_val("t2_w3_then", 3, 0);
    expect_val("t2_w3_else", 4, 1);
    expect_val("t2_valid", 5, 1);
    drain();
    const_addr = 1'b1;
    expect_val("t2_const1", 0, 32'h1234);
    drain();
    check_image("t2", IMG1);

    // 3: gapped stream, done exactly after beat 20
    pulse_start();
    send_beats(IMG2, 0, 18, 1'b1);
    repeat (3) begin
      prog_valid = 1'b0;
      cycle();
    end
    expect_val("t3_done_at19", 7, 0);
    expect_val("t3_ready_at19", 6, 1);
    drain();
    send_beats(IMG2, 19, 19, 1'b1);
    expect_val("t3_done_at20", 7, 1);
    expect_val("t3_ready_full", 6, 0);
    drain();
    check_image("t3_pre", IMG1);
    pulse_commit();
    check_image("t3", IMG2);

    // 4: early commit rejected
    pulse_start();
    send_beats(IMG1, 0, 6, 1'b0);
    pulse_commit();
    const_addr = 1'b0;
    expect_val("t4_err", 8, 1);
    expect_val("t4_const0_kept", 0, 32'hCAFE);
    drain();
    cycle();
    expect_val("t4_err_cleared", 8, 0);
    expect_val("t4_err_count", 9, 1);
    expect_val("t4_still_ready", 6, 1);
    drain();
    send_beats(IMG1, 7, 19, 1'b0);
    pulse_commit();
    check_image("t4", IMG1);

    // 5: shadow load leaves active bank untouched
    pulse_start();
    send_beats(IMG2, 0, 19, 1'b1);
    check_image("t5_pre", IMG1);
    pulse_commit();
    check_image("t5", IMG2);

    // 6: async reset mid-load, then restart from FULL
    pulse_start();
    send_beats(IMG1, 0, 4, 1'b0);
    #1;
    rst = 1'b1;
    addr = 3'd0; const_addr = 1'b0;
    expect_val("t6_rst_const", 0, 0);
    expect_val("t6_rst_jt", 1, 0);
    expect_val("t6_rst_valid", 5, 0);
    expect_val("t6_rst_ready", 6, 0);
    drain();
    rst = 1'b0;
    check_image("t6_zero", 80'h0);
    pulse_start();
    send_beats(IMG1, 0, 19, 1'b0);
    expect_val("t6_full", 7, 1);
    drain();
    prog_start = 1'b1;
    prog_commit = 1'b1;
    cycle();
    prog_start = 1'b0;
    prog_commit = 1'b0;
    expect_val("t6_restart_done", 7, 0);
    expect_val("t6_restart_err", 8, 0);
    expect_val("t6_no_commit_valid", 5, 0);
    drain();
    send_beats(IMG2, 0, 18, 1'b0);
    expect_val("t6_done_at19", 7, 0);
    drain();
    send_beats(IMG2, 19, 19, 1'b0);
    expect_val("t6_done_at20", 7, 1);
    drain();
    pulse_commit();
    expect_val("t6_valid", 5, 1);
    expect_val("t6_err_total", 9, 1);
    drain();
    check_image("t6", IMG2);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
